// File: rtl/reg_file_pw.sv
// Parametrised dual-write, dual-read register file with pair-write mode, port-1 write
// priority, collision flag, optional hardwired r0 and registered A/B operand latches.
module reg_file_pw #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic              LdAB,
    input  logic [ADDR_W-1:0] RWD,
    input  logic [ADDR_W-1:0] RWD2,
    input  logic              PairMode,
    input  logic [DATA_W-1:0] WB1,
    input  logic [DATA_W-1:0] WB2,
    input  logic              RegWr1,
    input  logic              RegWr2,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              Conflict
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] w2;
    logic              en1;
    logic              en2;
    logic              collide;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // Pair mode wraps naturally through the ADDR_W-bit add.
    assign w2 = PairMode ? RWD + ADDR_W'(1) : RWD2;

    assign collide = RegWr1 && RegWr2 && (RWD == w2);

    // Port 2 is suppressed on a collision so port 1 wins; r0 writes drop when hardwired.
    assign en1 = RegWr1 && !((ZERO_R0 != 0) && (RWD == '0));
    assign en2 = RegWr2 && !collide && !((ZERO_R0 != 0) && (w2 == '0));

    always_comb begin
        rd_a = regs[RA];
        if (BYPASS != 0) begin
            if (en2 && (w2 == RA)) rd_a = WB2;
            if (en1 && (RWD == RA)) rd_a = WB1;
        end
        if ((ZERO_R0 != 0) && (RA == '0)) rd_a = '0;
    end

    always_comb begin
        rd_b = regs[RB];
        if (BYPASS != 0) begin
            if (en2 && (w2 == RB)) rd_b = WB2;
            if (en1 && (RWD == RB)) rd_b = WB1;
        end
        if ((ZERO_R0 != 0) && (RB == '0)) rd_b = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (en1) regs[RWD] <= WB1;
            if (en2) regs[w2]  <= WB2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A        <= '0;
            B        <= '0;
            Conflict <= 1'b0;
        end else begin
            Conflict <= collide;
            if (LdAB) begin
                A <= rd_a;
                B <= rd_b;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_pw.sv
// Self-checking bench for reg_file_pw (default parameters: ZERO_R0=1, BYPASS=1).
module tb_reg_file_pw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  RA, RB, RWD, RWD2;
    logic        LdAB, PairMode, RegWr1, RegWr2;
    logic [31:0] WB1, WB2;
    logic [31:0] A, B;
    logic        Conflict;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0]  ra, rb;
        logic        ldab;
        logic [3:0]  rwd, rwd2;
        logic        pair;
        logic [31:0] wb1, wb2;
        logic        wr1, wr2;
        logic [31:0] exp_a, exp_b;
        logic        exp_c;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] a, b;
        logic        c;
    } exp_t;

    vec_t vecs [16];
    exp_t sb [$];

    reg_file_pw #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .RA(RA), .RB(RB), .LdAB(LdAB),
        .RWD(RWD), .RWD2(RWD2), .PairMode(PairMode), .WB1(WB1), .WB2(WB2),
        .RegWr1(RegWr1), .RegWr2(RegWr2), .A(A), .B(B), .Conflict(Conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic idle_inputs();
        RA = '0; RB = '0; LdAB = 0; RWD = '0; RWD2 = '0; PairMode = 0;
        WB1 = '0; WB2 = '0; RegWr1 = 0; RegWr2 = 0;
    endtask

    task automatic apply(input vec_t v);
        RA = v.ra; RB = v.rb; LdAB = v.ldab; RWD = v.rwd; RWD2 = v.rwd2;
        PairMode = v.pair; WB1 = v.wb1; WB2 = v.wb2; RegWr1 = v.wr1; RegWr2 = v.wr2;
    endtask

    initial begin
        exp_t e;
        //            ra  rb  ld rwd rwd2 pr  wb1           wb2           w1 w2  expA          expB          C
        vecs[0]  = '{4'd0, 4'd0, 0, 4'd3, 4'd0, 1, 32'h12345678, 32'hABCDEF01, 1, 1, 32'h0,        32'h0,        0};
        vecs[1]  = '{4'd3, 4'd4, 1, 4'd0, 4'd0, 0, 32'h0,        32'h0,        0, 0, 32'h12345678, 32'hABCDEF01, 0};
        vecs[2]  = '{4'd15,4'd0, 1, 4'd15,4'd0, 1, 32'h11111111, 32'h22222222, 1, 1, 32'h11111111, 32'h0,        0};
        vecs[3]  = '{4'd15,4'd0, 1, 4'd0, 4'd0, 0, 32'h0,        32'h0,        0, 0, 32'h11111111, 32'h0,        0};
        vecs[4]  = '{4'd6, 4'd6, 1, 4'd6, 4'd0, 0, 32'h00000001, 32'h0,        1, 0, 32'h00000001, 32'h00000001, 0};
        vecs[5]  = '{4'd5, 4'd5, 1, 4'd5, 4'd5, 0, 32'hAAAAAAAA, 32'h55555555, 1, 1, 32'hAAAAAAAA, 32'hAAAAAAAA, 1};
        vecs[6]  = '{4'd1, 4'd1, 0, 4'd0, 4'd0, 0, 32'h0,        32'h0,        0, 0, 32'hAAAAAAAA, 32'hAAAAAAAA, 0};
        vecs[7]  = '{4'd5, 4'd6, 1, 4'd0, 4'd0, 0, 32'h0,        32'h0,        0, 0, 32'hAAAAAAAA, 32'h00000001, 0};
        vecs[8]  = '{4'd2, 4'd2, 0, 4'd2, 4'd0, 0, 32'hDEADBEEF, 32'h0,        1, 0, 32'hAAAAAAAA, 32'h00000001, 0};
        vecs[9]  = '{4'd2, 4'd3, 1, 4'd0, 4'd0, 0, 32'h0,        32'h0,        0, 0, 32'hDEADBEEF, 32'h12345678, 0};
        vecs[10] = '{4'd0, 4'd2, 1, 4'd0, 4'd0, 0, 32'hFFFFFFFF, 32'hEEEEEEEE, 1, 1, 32'h0,        32'hDEADBEEF, 1};
        vecs[11] = '{4'd7, 4'd0, 1, 4'd0, 4'd7, 0, 32'h0,        32'h00000077, 0, 1, 32'h00000077, 32'h0,        0};
        vecs[12] = '{4'd8, 4'd9, 1, 4'd8, 4'd9, 0, 32'h00008888, 32'h00009999, 1, 1, 32'h00008888, 32'h00009999, 0};
        vecs[13] = '{4'd10,4'd10,1, 4'd10,4'd10,0, 32'h000000A0, 32'h000000B0, 1, 0, 32'h000000A0, 32'h000000A0, 0};
        vecs[14] = '{4'd11,4'd11,1, 4'd11,4'd11,0, 32'h000000A1, 32'h000000B1, 0, 1, 32'h000000B1, 32'h000000B1, 0};
        vecs[15] = '{4'd7, 4'd11,1, 4'd0, 4'd0, 0, 32'h0,        32'h0,        0, 0, 32'h00000077, 32'h000000B1, 0};

        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check32("reset_A", A, 32'h0);
        check32("reset_B", B, 32'h0);
        check1("reset_Conflict", Conflict, 1'b0);

        // Table-driven vectors through the scoreboard queue.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            sb.push_back('{i, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_c});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check32($sformatf("vec%0d_A", e.idx), A, e.a);
            check32($sformatf("vec%0d_B", e.idx), B, e.b);
            check1($sformatf("vec%0d_Conflict", e.idx), Conflict, e.c);
        end

        // Mid-run async reset while Conflict and A/B are non-zero.
        @(negedge clk);
        idle_inputs();
        RA = 4'd3; RB = 4'd15; LdAB = 1;
        RWD = 4'd12; RWD2 = 4'd12; WB1 = 32'h1; WB2 = 32'h2; RegWr1 = 1; RegWr2 = 1;
        @(posedge clk);
        #1;
        check32("prereset_A", A, 32'h12345678);
        check1("prereset_Conflict", Conflict, 1'b1);
        #2;
        rst_n = 0;
        #1;
        check32("async_reset_A", A, 32'h0);
        check32("async_reset_B", B, 32'h0);
        check1("async_reset_Conflict", Conflict, 1'b0);
        @(negedge clk);
        RA = 4'd5; RB = 4'd5; RWD = 4'd5; WB1 = 32'h5A5A5A5A; RegWr1 = 1; RegWr2 = 0; LdAB = 1;
        @(posedge clk);
        #1;
        check32("held_reset_A", A, 32'h0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        RA = 4'd5; RB = 4'd3; LdAB = 1;
        @(posedge clk);
        #1;
        check32("post_reset_r5", A, 32'h0);
        check32("post_reset_r3", B, 32'h0);

        @(negedge clk);
        idle_inputs();
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
